// File: rtl/gbc_vram_pkg.sv
// Shared VRAM definitions for the arbiter, the PPU and the memory-bus decoder.
package gbc_vram_pkg;

  localparam int unsigned VRAM_ADDR_W       = 14;
  localparam logic [7:0]  VRAM_LOCKOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    TRANSFER = 2'd3
  } ppu_mode_e;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_CPU_XFER = 2'd1,
    ARB_PPU_XFER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gbc_vram_arbiter.sv
// CPU/PPU arbiter for the CGB VRAM BRAM with mode-3 CPU lockout.
// The BRAM is expected to share ClkEn so RamDataIn only moves on enabled edges.
module gbc_vram_arbiter
  import gbc_vram_pkg::*;
#(
  parameter int unsigned AddrWidth  = VRAM_ADDR_W,
  parameter int unsigned CountWidth = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ClkEn,
  input  logic                  LcdEnable,
  input  logic [1:0]            PpuMode,
  input  logic                  VramBank,
  input  logic                  CpuAccess,
  input  logic                  CpuWrite,
  input  logic [12:0]           CpuAddress,
  input  logic [7:0]            CpuDataIn,
  output logic [7:0]            CpuDataOut,
  output logic                  CpuAck,
  input  logic                  PpuAccess,
  input  logic [AddrWidth-1:0]  PpuAddress,
  output logic [7:0]            PpuDataOut,
  output logic                  PpuAck,
  output logic                  RamAccess,
  output logic                  RamWrite,
  output logic [AddrWidth-1:0]  RamAddress,
  output logic [7:0]            RamDataOut,
  input  logic [7:0]            RamDataIn,
  output logic [CountWidth-1:0] LockoutCount
);

  arb_state_e            state_q, state_d;
  logic                  cpu_ack_q, ppu_ack_q;
  logic                  cpu_from_ram_q;
  logic                  lock_pend_q;
  logic                  ram_access_q, ram_write_q;
  logic [AddrWidth-1:0]  ram_addr_q;
  logic [7:0]            ram_wdata_q;
  logic [CountWidth-1:0] lock_cnt_q;

  ppu_mode_e             mode;
  logic                  lock_cond;
  logic                  cpu_free, ppu_free;
  logic                  cpu_req, ppu_grant, cpu_grant, cpu_lock;
  logic [AddrWidth-1:0]  cpu_addr;

  assign mode      = ppu_mode_e'(PpuMode);
  assign lock_cond = LcdEnable && (mode == TRANSFER);
  assign cpu_addr  = AddrWidth'({VramBank, CpuAddress});

  // Transfers always finish in one cycle, so a new grant may issue on the
  // completing edge; only the requester being acked is excluded.
  always_comb begin
    cpu_free  = !cpu_ack_q && !lock_pend_q && (state_q != ARB_CPU_XFER);
    ppu_free  = !ppu_ack_q && (state_q != ARB_PPU_XFER);
    cpu_req   = CpuAccess && cpu_free;
    ppu_grant = LcdEnable && PpuAccess && ppu_free;
    cpu_lock  = cpu_req && lock_cond;
    cpu_grant = cpu_req && !lock_cond && !ppu_grant;
    state_d   = ARB_IDLE;
    if (ppu_grant) begin
      state_d = ARB_PPU_XFER;
    end else if (cpu_grant) begin
      state_d = ARB_CPU_XFER;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= ARB_IDLE;
      cpu_ack_q      <= 1'b0;
      ppu_ack_q      <= 1'b0;
      cpu_from_ram_q <= 1'b0;
      lock_pend_q    <= 1'b0;
      ram_access_q   <= 1'b0;
      ram_write_q    <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      lock_cnt_q     <= '0;
    end else if (ClkEn) begin
      state_q        <= state_d;
      cpu_ack_q      <= (state_q == ARB_CPU_XFER) || lock_pend_q;
      cpu_from_ram_q <= (state_q == ARB_CPU_XFER);
      ppu_ack_q      <= (state_q == ARB_PPU_XFER);
      lock_pend_q    <= cpu_lock;
      ram_access_q   <= ppu_grant || cpu_grant;
      ram_write_q    <= cpu_grant && CpuWrite;
      if (ppu_grant) begin
        ram_addr_q <= PpuAddress;
      end else if (cpu_grant) begin
        ram_addr_q  <= cpu_addr;
        ram_wdata_q <= CpuDataIn;
      end
      if (cpu_lock && (lock_cnt_q != '1)) begin
        lock_cnt_q <= lock_cnt_q + CountWidth'(1);
      end
    end
  end

  // BRAM read data arrives with the Ack, so it is steered rather than re-registered.
  assign CpuDataOut   = !cpu_ack_q ? '0 :
                        (cpu_from_ram_q ? RamDataIn : VRAM_LOCKOUT_DATA);
  assign PpuDataOut   = ppu_ack_q ? RamDataIn : '0;
  assign CpuAck       = cpu_ack_q;
  assign PpuAck       = ppu_ack_q;
  assign RamAccess    = ram_access_q;
  assign RamWrite     = ram_write_q;
  assign RamAddress   = ram_addr_q;
  assign RamDataOut   = ram_wdata_q;
  assign LockoutCount = lock_cnt_q;

endmodule

// File: tb/tb_gbc_vram_arbiter.sv
// Scoreboard bench for gbc_vram_arbiter: stimulus queues expectations, a negedge monitor checks them.
module tb_gbc_vram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ClkEn;
  logic        LcdEnable;
  logic [1:0]  PpuMode;
  logic        VramBank;
  logic        CpuAccess;
  logic        CpuWrite;
  logic [12:0] CpuAddress;
  logic [7:0]  CpuDataIn;
  logic [7:0]  CpuDataOut;
  logic        CpuAck;
  logic        PpuAccess;
  logic [13:0] PpuAddress;
  logic [7:0]  PpuDataOut;
  logic        PpuAck;
  logic        RamAccess;
  logic        RamWrite;
  logic [13:0] RamAddress;
  logic [7:0]  RamDataOut;
  logic [7:0]  RamDataIn;
  logic [7:0]  LockoutCount;

  gbc_vram_arbiter #(.AddrWidth(14), .CountWidth(8)) dut (
    .Clk(clk), .Reset(rst_n), .ClkEn(ClkEn), .LcdEnable(LcdEnable),
    .PpuMode(PpuMode), .VramBank(VramBank), .CpuAccess(CpuAccess),
    .CpuWrite(CpuWrite), .CpuAddress(CpuAddress), .CpuDataIn(CpuDataIn),
    .CpuDataOut(CpuDataOut), .CpuAck(CpuAck), .PpuAccess(PpuAccess),
    .PpuAddress(PpuAddress), .PpuDataOut(PpuDataOut), .PpuAck(PpuAck),
    .RamAccess(RamAccess), .RamWrite(RamWrite), .RamAddress(RamAddress),
    .RamDataOut(RamDataOut), .RamDataIn(RamDataIn), .LockoutCount(LockoutCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered read-first BRAM on the shared clock enable.
  logic [7:0] mem [0:16383];
  always @(posedge clk) begin
    if (ClkEn && RamAccess) begin
      if (RamWrite) mem[RamAddress] <= RamDataOut;
      RamDataIn <= mem[RamAddress];
    end
  end

  int unsigned ecyc = 0;
  always @(posedge clk) begin
    if (ClkEn) ecyc <= ecyc + 1;
  end

  typedef struct {
    logic [7:0]  data;
    bit          chk;
    int unsigned at;
    string       name;
  } ack_exp_t;

  typedef enum {P_RESET, P_LOCKCNT, P_MEM, P_CPUACK, P_FLAG} probe_e;

  typedef struct {
    probe_e      kind;
    logic [13:0] addr;
    logic [63:0] act;
    logic [63:0] exp;
    string       name;
  } probe_t;

  ack_exp_t cpu_q[$];
  ack_exp_t ppu_q[$];
  probe_t   probe_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          done = 1'b0;
  bit          finished = 1'b0;
  probe_t      mon_p;
  ack_exp_t    mon_e;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (probe_q.size() > 0) begin
      mon_p = probe_q.pop_front();
      case (mon_p.kind)
        P_RESET:   check(mon_p.name, 64'({CpuAck, PpuAck, RamAccess, RamWrite, CpuDataOut,
                                          PpuDataOut, RamAddress, RamDataOut, LockoutCount}),
                         mon_p.exp);
        P_LOCKCNT: check(mon_p.name, 64'(LockoutCount), mon_p.exp);
        P_MEM:     check(mon_p.name, 64'(mem[mon_p.addr]), mon_p.exp);
        P_CPUACK:  check(mon_p.name, 64'({CpuAck, CpuDataOut}), mon_p.exp);
        default:   check(mon_p.name, mon_p.act, mon_p.exp);
      endcase
    end
    if (ClkEn && rst_n) begin
      if (CpuAck) begin
        if (cpu_q.size() == 0) begin
          check("cpu_unexpected_ack", 64'(CpuAck), 64'd0);
        end else begin
          mon_e = cpu_q.pop_front();
          if (mon_e.chk) check({mon_e.name, "_data"}, 64'(CpuDataOut), 64'(mon_e.data));
          check({mon_e.name, "_cycle"}, 64'(ecyc), 64'(mon_e.at));
        end
      end
      if (PpuAck) begin
        if (ppu_q.size() == 0) begin
          check("ppu_unexpected_ack", 64'(PpuAck), 64'd0);
        end else begin
          mon_e = ppu_q.pop_front();
          check({mon_e.name, "_data"}, 64'(PpuDataOut), 64'(mon_e.data));
          check({mon_e.name, "_cycle"}, 64'(ecyc), 64'(mon_e.at));
        end
      end
    end
    if (done && !finished) begin
      check("cpu_acks_outstanding", 64'(cpu_q.size()), 64'd0);
      check("ppu_acks_outstanding", 64'(ppu_q.size()), 64'd0);
      finished = 1'b1;
    end
  end

  task automatic step_en(input bit en);
    @(posedge clk);
    #1;
    if (CpuAck) CpuAccess = 1'b0;
    if (PpuAck) PpuAccess = 1'b0;
    ClkEn = en;
  endtask

  task automatic probe(input probe_e k, input logic [13:0] a, input logic [63:0] exp, input string nm);
    probe_q.push_back('{k, a, 64'd0, exp, nm});
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while ((CpuAccess || PpuAccess) && n < budget) begin
      step_en(1'b1);
      n++;
    end
    probe_q.push_back('{P_FLAG, 14'd0, 64'({CpuAccess, PpuAccess}), 64'd0, "req_ack_timeout"});
    CpuAccess = 1'b0;
    PpuAccess = 1'b0;
    step_en(1'b1);
  endtask

  // lat: enabled edges from issue to the edge that raises the Ack.
  task automatic cpu_issue(input bit wr, input bit bank, input logic [12:0] a, input logic [7:0] d,
                           input bit chk, input logic [7:0] exp, input int unsigned lat,
                           input string nm);
    CpuWrite   = wr;
    VramBank   = bank;
    CpuAddress = a;
    CpuDataIn  = d;
    CpuAccess  = 1'b1;
    cpu_q.push_back('{exp, chk, ecyc + lat, nm});
  endtask

  task automatic ppu_issue(input logic [13:0] a, input logic [7:0] exp, input int unsigned lat,
                           input string nm);
    PpuAddress = a;
    PpuAccess  = 1'b1;
    ppu_q.push_back('{exp, 1'b1, ecyc + lat, nm});
  endtask

  initial begin
    rst_n = 1'b0; ClkEn = 1'b1; LcdEnable = 1'b1; PpuMode = 2'd0; VramBank = 1'b0;
    CpuAccess = 1'b0; CpuWrite = 1'b0; CpuAddress = '0; CpuDataIn = '0;
    PpuAccess = 1'b0; PpuAddress = '0;
    step_en(1'b1);
    step_en(1'b1);
    probe(P_RESET, 14'd0, 64'd0, "reset_outputs");
    step_en(1'b1);
    rst_n = 1'b1;
    step_en(1'b1);

    // Mode 0: real accesses in both banks.
    PpuMode = 2'd0;
    cpu_issue(1'b1, 1'b1, 13'h0010, 8'h5A, 1'b0, 8'h00, 2, "m0_wr_bank1");
    wait_done(10);
    probe(P_MEM, 14'h2010, 64'h5A, "m0_mem_2010");
    cpu_issue(1'b1, 1'b0, 13'h0000, 8'hC3, 1'b0, 8'h00, 2, "m0_wr_bank0");
    wait_done(10);
    probe(P_MEM, 14'h0000, 64'hC3, "m0_mem_0000");
    cpu_issue(1'b0, 1'b1, 13'h0010, 8'h00, 1'b1, 8'h5A, 2, "m0_rd_bank1");
    wait_done(10);

    // Mode 3: lockout drops writes and reads back 0xFF.
    PpuMode = 2'd3;
    cpu_issue(1'b1, 1'b1, 13'h0010, 8'h33, 1'b0, 8'h00, 2, "m3_wr_locked");
    wait_done(10);
    cpu_issue(1'b0, 1'b1, 13'h0010, 8'h00, 1'b1, 8'hFF, 2, "m3_rd_locked");
    wait_done(10);
    probe(P_MEM, 14'h2010, 64'h5A, "m3_mem_unchanged");
    probe(P_LOCKCNT, 14'd0, 64'd2, "m3_lockcnt");

    // Mode 2: PPU wins, CPU follows one cycle later.
    PpuMode = 2'd2;
    ppu_issue(14'h2010, 8'h5A, 2, "m2_ppu_first");
    cpu_issue(1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 8'hC3, 3, "m2_cpu_second");
    wait_done(10);

    // Mode 3: PPU fetch and locked CPU read complete together.
    PpuMode = 2'd3;
    ppu_issue(14'h0000, 8'hC3, 2, "m3_ppu_fetch");
    cpu_issue(1'b0, 1'b1, 13'h0010, 8'h00, 1'b1, 8'hFF, 2, "m3_cpu_parallel");
    wait_done(10);
    probe(P_LOCKCNT, 14'd0, 64'd3, "m3_par_lockcnt");

    // Clock enable 1-0-0-1 across a CPU read; Ack holds through disabled cycles.
    PpuMode = 2'd0;
    cpu_issue(1'b0, 1'b1, 13'h0010, 8'h00, 1'b1, 8'h5A, 2, "ce_rd");
    step_en(1'b0);
    step_en(1'b0);
    step_en(1'b1);
    step_en(1'b0);
    probe(P_CPUACK, 14'd0, 64'h15A, "ce_ack_hold1");
    step_en(1'b0);
    probe(P_CPUACK, 14'd0, 64'h15A, "ce_ack_hold2");
    step_en(1'b1);
    step_en(1'b1);

    // LCD off in mode 3: CPU write lands, PPU is never served.
    LcdEnable = 1'b0;
    PpuMode   = 2'd3;
    PpuAddress = 14'h0020;
    PpuAccess  = 1'b1;
    cpu_issue(1'b1, 1'b0, 13'h0020, 8'h77, 1'b0, 8'h00, 2, "lcdoff_wr");
    repeat (6) step_en(1'b1);
    probe_q.push_back('{P_FLAG, 14'd0, 64'(CpuAccess), 64'd0, "lcdoff_cpu_done"});
    PpuAccess = 1'b0;
    CpuAccess = 1'b0;
    step_en(1'b1);
    probe(P_MEM, 14'h0020, 64'h77, "lcdoff_mem_0020");
    probe(P_LOCKCNT, 14'd0, 64'd3, "lcdoff_lockcnt");

    // Saturation: bring the counter to 0xFE, then three more lockouts.
    LcdEnable = 1'b1;
    for (int i = 0; i < 251; i++) begin
      cpu_issue(1'b1, 1'b0, 13'h0001, 8'h11, 1'b1, 8'hFF, 2, "sat_fill");
      wait_done(10);
    end
    probe(P_LOCKCNT, 14'd0, 64'hFE, "sat_lockcnt_fe");
    for (int i = 0; i < 3; i++) begin
      cpu_issue(1'b0, 1'b0, 13'h0001, 8'h00, 1'b1, 8'hFF, 2, "sat_edge");
      wait_done(10);
      probe(P_LOCKCNT, 14'd0, 64'hFF, "sat_lockcnt_ff");
    end

    // Reset during CPU_XFER aborts the read with no Ack.
    PpuMode = 2'd0;
    CpuWrite = 1'b0; VramBank = 1'b1; CpuAddress = 13'h0010; CpuAccess = 1'b1;
    step_en(1'b1);
    #2;
    rst_n = 1'b0;
    CpuAccess = 1'b0;
    probe(P_RESET, 14'd0, 64'd0, "reset_mid_xfer");
    step_en(1'b1);
    step_en(1'b1);
    rst_n = 1'b1;
    repeat (4) step_en(1'b1);

    done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!finished) @(posedge clk);
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gbc_vram_arbiter.md
# gbc_vram_arbiter

Arbitrates the Game Boy Color video RAM between the CPU memory bus and the PPU fetch engine. It sits between the system memory bus decode for 0x8000–0x9FFF and the 16 KiB VRAM BRAM. It enforces CGB mode-3 lockout: CPU writes are dropped and CPU reads return 0xFF. All sequencing runs on the CATC clock-enable, so the block stalls with the rest of the core.

## Interface
Parameters:
- AddrWidth, 14: BRAM word address width (two 8 KiB banks).
- CountWidth, 16: width of the lockout event counter.

Ports:
- Clk  input  1  core clock; the single clock of the block.
- Reset  input  1  asynchronous, active-low reset.
- ClkEn  input  1  CATC clock-enable. State advances only when it is 1.
- LcdEnable  input  1  LCDC bit 7. When 0, no lockout applies and PPU requests are ignored.
- PpuMode  input  2  STAT mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 transfer).
- VramBank  input  1  VBK bit 0; supplies address bit 13 for CPU accesses.
- CpuAccess  input  1  CPU request. Held high until CpuAck.
- CpuWrite  input  1  1 = write, 0 = read; valid with CpuAccess.
- CpuAddress  input  13  offset within 0x8000–0x9FFF.
- CpuDataIn  input  8  write data.
- CpuDataOut  output  8  read data; valid while CpuAck is 1.
- CpuAck  output  1  one-enabled-cycle completion pulse.
- PpuAccess  input  1  PPU fetch request. Held high until PpuAck.
- PpuAddress  input  AddrWidth  full VRAM address, bank included.
- PpuDataOut  output  8  fetch data; valid while PpuAck is 1.
- PpuAck  output  1  one-enabled-cycle completion pulse.
- RamAccess, RamWrite  output  1 each  BRAM strobe and write enable.
- RamAddress  output  AddrWidth  BRAM address.
- RamDataOut  output  8  BRAM write data.
- RamDataIn  input  8  BRAM read data; registered, 1-cycle latency.
- LockoutCount  output  CountWidth  saturating count of locked-out CPU accesses.

## Operation
- States: IDLE, CPU_XFER, PPU_XFER.
- IDLE, PPU grant: LcdEnable=1 and PpuAccess=1 → drive BRAM with PpuAddress as a read, go to PPU_XFER.
- IDLE, CPU grant: when there is no PPU grant and CpuAccess=1 with no lockout → drive BRAM with {VramBank, CpuAddress}, RamWrite=CpuWrite, go to CPU_XFER.
- Lockout condition: LcdEnable=1 and PpuMode=3, evaluated at acceptance.
- Lockout path: a locked-out CPU request never touches BRAM and is answered the next enabled cycle.
  - Reads return CpuDataOut=0xFF; writes are discarded.
  - LockoutCount increments, saturating at all-ones.
  - This path runs in parallel with a PPU grant in the same cycle.
- CPU_XFER: CpuAck=1 and CpuDataOut=RamDataIn (reads), then IDLE.
- PPU_XFER: PpuAck=1 and PpuDataOut=RamDataIn, then IDLE.
- Priority: the PPU beats the CPU. A CPU request that loses arbitration waits; at most one PPU transfer precedes it unless PpuAccess stays asserted. The PPU drops PpuAccess outside mode 3, so CPU starvation is bounded by design.
- A request is not re-accepted in the cycle its Ack is high. The requester must deassert or present a new request after the Ack.
- Mode change mid-transfer: the decision made at acceptance stands. A CPU access granted in mode 2 completes normally even if mode 3 begins before its Ack.
- LcdEnable=0: PpuAccess is ignored (PpuAck stays 0). The CPU always gets real BRAM access.

## Timing
- Reset (async assert, sync release):
  - State IDLE.
  - CpuAck=PpuAck=RamAccess=RamWrite=0.
  - CpuDataOut=PpuDataOut=0; RamAddress=0; RamDataOut=0; LockoutCount=0.
- Reset asserted mid-transfer aborts the transfer. No Ack is issued, and a pending BRAM write may or may not land.
- Latency, counted in enabled cycles from acceptance at N:
  - BRAM access, Ack and data all at N+1.
  - Lockout response at N+1.
  - CPU blocked by the PPU: acceptance at the first IDLE cycle with no PPU grant.
- ClkEn=0: all registers hold. Acks stay asserted until the next enabled cycle; a downstream consumer samples Acks on enabled cycles.
- Ram* outputs are registered and asserted for exactly one enabled cycle per grant.

## Structure
- Shared package gbc_vram_pkg holds:
  - the PpuMode enum (HBLANK, VBLANK, OAM_SCAN, TRANSFER);
  - the arbiter state enum;
  - constants VRAM_LOCKOUT_DATA=8'hFF and VRAM_ADDR_W=14.
- The package is shared with the PPU and the memory-bus decoder.
- No sub-module is needed. The saturating counter and the grant logic stay inline; the block is a single module.

## Test plan
- Mode 0, CPU write 0x5A at 0x0010 with VramBank=1, then read back → BRAM word 0x2010=0x5A; read returns 0x5A; each Ack exactly one cycle after acceptance.
- Mode 3, CPU write 0x33 at 0x0010, then read → BRAM unchanged at 0x5A; read returns 0xFF; LockoutCount=2.
- Same cycle, PpuAccess at 0x2010 and CpuAccess read at 0x0000, mode 2 → PpuAck at N+1 with 0x5A; CpuAck at N+2.
- Mode 3 with PPU fetch and locked-out CPU read in the same cycle → both Acks at N+1; PpuDataOut=BRAM data; CpuDataOut=0xFF.
- ClkEn toggling 1-0-0-1 during a CPU read → Ack appears on the second enabled cycle and holds through the disabled cycles. LcdEnable=0 with mode 3 → CPU write lands; PPU request never acked.
- Force LockoutCount to 0xFFFE, then issue 3 locked accesses → saturates at 0xFFFF. Assert Reset during CPU_XFER → all outputs return to their reset values immediately, and no Ack is issued.
